prog_loader: RTL and testbench

- Upstream boot stage for the 8-bit Redux core.
- Receives a program over a UART 8N1 serial line and writes it byte-by-byte into the instruction memory's write port.
- Holds the core halted (core_run low) until the image is complete.
- Sits between the board serial pin and the instruction_memory/program_counter of the core.

---
 rtl/redux_pkg.sv | 28 ++
 rtl/prog_loader_if.sv | 11 +
 rtl/prog_loader_uart_rx.sv | 101 ++++++++++
 rtl/prog_loader.sv | 126 ++++++++++++
 tb/tb_prog_loader.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/redux_pkg.sv
// Shared types and constants for the Redux boot loader.
// Optional build macro used by the loader: PROG_LOADER_CHECKSUM_EN.
package redux_pkg;

    localparam int IMEM_ADDR_W = 8;
    localparam int IMEM_DEPTH  = 256;

    typedef enum logic [2:0] {
        LEN   = 3'd0,
        LOAD  = 3'd1,
        CHECK = 3'd2,
        RUN   = 3'd3,
        ERR   = 3'd4
    } loader_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    // Length header byte: 0 encodes a full 256-byte image.
    function automatic logic [8:0] len_decode(input logic [7:0] n);
        return (n == 8'd0) ? 9'd256 : {1'b0, n};
    endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Instruction-memory write port driven by the loader.
interface prog_loader_if;
    import redux_pkg::*;

    logic                   we;
    logic [IMEM_ADDR_W-1:0] addr;
    logic [7:0]             wdata;

    modport master (output we, addr, wdata);
    modport slave  (input  we, addr, wdata);
endinterface

// File: rtl/prog_loader_uart_rx.sv
// UART 8N1 receiver: 2-flop synchronizer, mid-bit sampling, glitch
// rejection on the start bit, one-cycle rx_valid / frame_err pulses.
module uart_rx
    import redux_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       frame_err,
    output logic       start_ok
);
    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);

    logic        rx_meta, rx_sync, rx_prev;
    rx_state_t   state_q, state_d;
    logic [15:0] cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shreg;
    logic        fall, tick_half, tick_bit;

    assign fall      = rx_prev & ~rx_sync;
    assign tick_half = (cnt == HALF_LAST);
    assign tick_bit  = (cnt == BIT_LAST);

    // Synchronize the asynchronous line; preset high so reset looks idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // Receiver state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= RX_IDLE;
        else        state_q <= state_d;
    end

    // Next state: a start edge that is high again at half bit is a glitch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RX_IDLE:  if (fall) state_d = RX_START;
            RX_START: if (tick_half) state_d = rx_sync ? RX_IDLE : RX_DATA;
            RX_DATA:  if (tick_bit && bit_idx == 3'd7) state_d = RX_STOP;
            RX_STOP:  if (tick_bit) state_d = RX_IDLE;
            default:  state_d = RX_IDLE;
        endcase
    end

    // Bit timer, LSB-first shift register and result pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            rx_valid  <= 1'b0;
            rx_data   <= '0;
            frame_err <= 1'b0;
            start_ok  <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            start_ok  <= 1'b0;
            if (state_q == RX_IDLE || state_d != state_q || (state_q == RX_DATA && tick_bit))
                cnt <= '0;
            else
                cnt <= cnt + 16'd1;
            case (state_q)
                RX_START: if (tick_half && !rx_sync) begin
                    start_ok <= 1'b1;
                    bit_idx  <= '0;
                end
                RX_DATA: if (tick_bit) begin
                    shreg   <= {rx_sync, shreg[7:1]};
                    bit_idx <= bit_idx + 3'd1;
                end
                RX_STOP: if (tick_bit) begin
                    if (rx_sync) begin
                        rx_valid <= 1'b1;
                        rx_data  <= shreg;
                    end else begin
                        frame_err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Boot loader: receives a length-prefixed image over UART, writes it to
// instruction memory, then releases the core.
// Build macro PROG_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte.
module prog_loader
    import redux_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter logic [7:0]  BASE_ADDR    = 8'h00
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          rx,
    input  logic          reload,
    prog_loader_if.master imem,
    output logic          core_run,
    output logic          busy,
    output logic          error,
    output logic [7:0]    byte_count
);
    logic          rx_valid, frame_err, start_ok;
    logic [7:0]    rx_data;
    loader_state_t state_q, state_d;
    logic [7:0]    addr_q;
    logic [8:0]    len9, cnt9;
    logic          seen, last_byte;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0]    csum;
`endif

    uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .frame_err (frame_err),
        .start_ok  (start_ok)
    );

    // 9-bit write count so a 256-byte image completes correctly.
    assign last_byte = ((cnt9 + 9'd1) == len9);
    assign busy      = (state_q == LOAD) || (state_q == LEN && seen);

    // Loader state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= LEN;
        else        state_q <= state_d;
    end

    // Next state; reload overrides everything, including a coincident byte.
    always_comb begin
        state_d = state_q;
        if (reload) begin
            state_d = LEN;
        end else begin
            unique case (state_q)
                LEN:  if (rx_valid) state_d = LOAD;
`ifdef PROG_LOADER_CHECKSUM_EN
                LOAD:  if (rx_valid && last_byte) state_d = CHECK;
                CHECK: if (rx_valid) state_d = (rx_data == csum) ? RUN : ERR;
`else
                LOAD:  if (rx_valid && last_byte) state_d = RUN;
`endif
                default: ;
            endcase
        end
    end

    // Registered write port, counters, run/error flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imem.we    <= 1'b0;
            imem.addr  <= '0;
            imem.wdata <= '0;
            core_run   <= 1'b0;
            error      <= 1'b0;
            byte_count <= '0;
            addr_q     <= '0;
            len9       <= '0;
            cnt9       <= '0;
            seen       <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum       <= '0;
`endif
        end else begin
            imem.we  <= 1'b0;
            // One cycle behind the state so release follows the final write.
            core_run <= !reload && (state_q == RUN);
            if (reload) begin
                error      <= 1'b0;
                byte_count <= '0;
                cnt9       <= '0;
                seen       <= 1'b0;
            end else begin
                if (frame_err || state_d == ERR) error <= 1'b1;
                if (start_ok && state_q == LEN) seen <= 1'b1;
                if (rx_valid) begin
                    case (state_q)
                        LEN: begin
                            len9       <= len_decode(rx_data);
                            addr_q     <= BASE_ADDR;
                            byte_count <= '0;
                            cnt9       <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
                            csum       <= '0;
`endif
                        end
                        LOAD: begin
                            imem.we    <= 1'b1;
                            imem.addr  <= addr_q;
                            imem.wdata <= rx_data;
                            addr_q     <= addr_q + 8'd1;
                            byte_count <= byte_count + 8'd1;
                            cnt9       <= cnt9 + 9'd1;
`ifdef PROG_LOADER_CHECKSUM_EN
                            csum       <= csum ^ rx_data;
`endif
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: two instances (base 00 and FE) share one serial
// line; an image-level reference predicts every write and flag.
module tb_prog_loader;
    localparam int CPB = 16;

    typedef logic [7:0] bq_t[$];
    typedef struct { logic [7:0] addr; logic [7:0] data; int cyc; } wr_t;
    typedef wr_t wq_t[$];

    logic clk = 1'b0;
    logic rst_n, rx, reload;
    logic run_a, busy_a, err_a, run_b, busy_b, err_b;
    logic [7:0] bc_a, bc_b;
    int tests = 0, fails = 0, cyc = 0, rise_a = -1, rise_b = -1;
    logic prev_a = 1'b0, prev_b = 1'b0;
    wq_t wa, wb;

    prog_loader_if ia();
    prog_loader_if ib();

    prog_loader #(.CLKS_PER_BIT(CPB), .BASE_ADDR(8'h00)) dut_a (
        .clk(clk), .rst_n(rst_n), .rx(rx), .reload(reload), .imem(ia),
        .core_run(run_a), .busy(busy_a), .error(err_a), .byte_count(bc_a));

    prog_loader #(.CLKS_PER_BIT(CPB), .BASE_ADDR(8'hFE)) dut_b (
        .clk(clk), .rst_n(rst_n), .rx(rx), .reload(reload), .imem(ib),
        .core_run(run_b), .busy(busy_b), .error(err_b), .byte_count(bc_b));

    always #5 clk = ~clk;

    // Capture every memory write and the first cycle of each core release.
    always @(negedge clk) begin
        cyc++;
        if (ia.we === 1'b1) wa.push_back('{ia.addr, ia.wdata, cyc});
        if (ib.we === 1'b1) wb.push_back('{ib.addr, ib.wdata, cyc});
        if (run_a === 1'b1 && !prev_a) rise_a = cyc;
        if (run_b === 1'b1 && !prev_b) rise_b = cyc;
        prev_a = (run_a === 1'b1);
        prev_b = (run_b === 1'b1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One 8N1 frame, LSB first, followed by a short idle gap.
    task automatic send_byte(input logic [7:0] b, input logic stop);
        logic [9:0] frame;
        frame = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = frame[i];
            repeat (CPB) @(posedge clk);
            #1;
        end
        rx = 1'b1;
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic pulse_reload(input string tag);
        @(posedge clk); #1 reload = 1'b1;
        @(posedge clk); #1 reload = 1'b0;
        @(negedge clk);
        chk({tag, " reload core_run A"}, 32'(run_a), 0);
        chk({tag, " reload core_run B"}, 32'(run_b), 0);
        chk({tag, " reload byte_count"}, 32'(bc_a), 0);
        chk({tag, " reload error"}, 32'(err_a), 0);
    endtask

    task automatic check_session(input string tag, input logic [7:0] base, input wq_t q,
                                 input int rise, input bq_t img, input logic [7:0] bc,
                                 input logic run);
        chk({tag, " writes"}, q.size(), img.size());
        for (int i = 0; i < img.size() && i < q.size(); i++) begin
            chk({tag, " addr"}, 32'(q[i].addr), 32'(8'(base + i)));
            chk({tag, " data"}, 32'(q[i].data), 32'(img[i]));
        end
        chk({tag, " core_run"}, 32'(run), 1);
        chk({tag, " byte_count"}, 32'(bc), 32'(8'(img.size())));
`ifndef PROG_LOADER_CHECKSUM_EN
        if (q.size() > 0) chk({tag, " run latency"}, rise, q[q.size()-1].cyc + 1);
`endif
    endtask

    // Full load: length header, image (optionally a bad-stop frame before
    // index bad_at), then compare both instances against the image.
    task automatic run_load(input string tag, input bq_t img, input int bad_at);
`ifdef PROG_LOADER_CHECKSUM_EN
        logic [7:0] ck;
        ck = 8'h00;
`endif
        wa.delete(); wb.delete();
        rise_a = -1; rise_b = -1;
        send_byte(8'(img.size()), 1'b1);
        chk({tag, " busy loading"}, 32'(busy_a), 1);
        for (int i = 0; i < img.size(); i++) begin
            if (i == bad_at) begin
                send_byte(8'h55, 1'b0);
                chk({tag, " ferr no write"}, wa.size(), i);
                chk({tag, " ferr error"}, 32'(err_a), 1);
                chk({tag, " ferr byte_count"}, 32'(bc_a), 32'(8'(i)));
            end
            send_byte(img[i], 1'b1);
`ifdef PROG_LOADER_CHECKSUM_EN
            ck ^= img[i];
`endif
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        send_byte(ck, 1'b1);
`endif
        check_session({tag, " A"}, 8'h00, wa, rise_a, img, bc_a, run_a);
        check_session({tag, " B"}, 8'hFE, wb, rise_b, img, bc_b, run_b);
        chk({tag, " error"}, 32'(err_a), (bad_at >= 0) ? 1 : 0);
        chk({tag, " busy done"}, 32'(busy_a), 0);
    endtask

    initial begin
        bq_t img;
        int n;
        rst_n = 1'b0; rx = 1'b1; reload = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("reset core_run", 32'(run_a), 0);
        chk("reset busy", 32'(busy_a), 0);
        chk("reset error", 32'(err_a), 0);
        chk("reset byte_count", 32'(bc_a), 0);
        chk("reset we", 32'(ia.we), 0);
        chk("reset addr", 32'(ia.addr), 0);

        // Short low glitch: rejected at the half-bit check.
        @(posedge clk); #1 rx = 1'b0;
        repeat (3) @(posedge clk);
        #1 rx = 1'b1;
        repeat (40) @(posedge clk);
        @(negedge clk);
        chk("glitch writes", wa.size(), 0);
        chk("glitch busy", 32'(busy_a), 0);
        chk("glitch error", 32'(err_a), 0);

        img = '{8'h81, 8'h42, 8'hF0};
        run_load("basic", img, -1);

        // Bytes after release are ignored.
        n = wa.size();
        send_byte(8'hA5, 1'b1);
        chk("run ignore writes", wa.size(), n);
        chk("run ignore core_run", 32'(run_a), 1);

        pulse_reload("s2");
        img = {};
        for (int i = 0; i < 4; i++) img.push_back(8'($urandom));
        run_load("wrap4", img, -1);

        pulse_reload("s3");
        img = {};
        for (int i = 0; i < 3; i++) img.push_back(8'($urandom));
        run_load("frame", img, 1);

        // Abort after two of five bytes; next byte is a fresh length.
        pulse_reload("s4");
        send_byte(8'd5, 1'b1);
        send_byte(8'($urandom), 1'b1);
        send_byte(8'($urandom), 1'b1);
        chk("midload byte_count", 32'(bc_a), 2);
        pulse_reload("midload");
        img = {};
        for (int i = 0; i < 2; i++) img.push_back(8'($urandom));
        run_load("relen", img, -1);

        for (int r = 0; r < 2; r++) begin
            pulse_reload("rnd");
            img = {};
            n = $urandom_range(1, 8);
            for (int i = 0; i < n; i++) img.push_back(8'($urandom));
            run_load("rnd", img, -1);
        end

        // Full 256-byte image: header 0, byte_count wraps to 0.
        pulse_reload("full");
        img = {};
        for (int i = 0; i < 256; i++) img.push_back(8'($urandom));
        run_load("full256", img, -1);

`ifdef PROG_LOADER_CHECKSUM_EN
        pulse_reload("ck_ok");
        wa.delete();
        send_byte(8'd2, 1'b1); send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1); send_byte(8'h26, 1'b1);
        chk("ck_ok core_run", 32'(run_a), 1);
        chk("ck_ok error", 32'(err_a), 0);
        chk("ck_ok writes", wa.size(), 2);
        pulse_reload("ck_bad");
        wa.delete();
        send_byte(8'd2, 1'b1); send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1); send_byte(8'h27, 1'b1);
        chk("ck_bad core_run", 32'(run_a), 0);
        chk("ck_bad error", 32'(err_a), 1);
        chk("ck_bad writes", wa.size(), 2);
        chk("ck_bad busy", 32'(busy_a), 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
